rx_sample_timer: RTL

RX_SAMPLE_TIMER -- requirements
Module: rx_sample_timer

---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/rx_sample_timer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: timer FSM encoding and legal configuration constants.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned PRESCALE_8         = 8;
    localparam int unsigned PRESCALE_16        = 16;
    localparam int unsigned PRESCALE_32        = 32;
    localparam int unsigned DEFAULT_PRESCALE   = PRESCALE_8;
    localparam int unsigned DEFAULT_FRAME_BITS = 10;
    localparam int unsigned MIN_FRAME_BITS     = 2;
    localparam int unsigned MAX_FRAME_BITS     = 15;

endpackage

// File: rtl/rx_sample_timer.sv
// UART RX oversample timer: tracks position within bit and frame, and flags the three
// majority-vote sample points around the bit centre.
module rx_sample_timer
    import uart_rx_pkg::*;
#(
    parameter int unsigned MAX_PRESCALE = 32,
    parameter int unsigned EDGE_W       = $clog2(MAX_PRESCALE),
    parameter int unsigned BIT_W        = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    input  logic              reset_bit_cnt,
    input  logic [EDGE_W:0]   prescale,
    input  logic [BIT_W-1:0]  frame_bits,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              sample_stb,
    output logic [1:0]        sample_idx,
    output logic              bit_end,
    output logic              frame_done,
    output logic              cfg_err
);

    state_e            state_q, state_d;
    logic [EDGE_W:0]   presc_q, presc_d;
    logic [BIT_W-1:0]  fbits_q, fbits_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              frame_done_q, frame_done_d;
    logic              cfg_err_q, cfg_err_d;

    logic              presc_ok, fbits_ok, running, final_bit;
    logic [31:0]       fbits_ext;
    logic [EDGE_W-1:0] last_edge, mid_lo, win_off;

    // Config legality is judged on the raw inputs at frame start only.
    assign fbits_ext = 32'(frame_bits);
    assign presc_ok  = (prescale == (EDGE_W+1)'(PRESCALE_8))  ||
                       (prescale == (EDGE_W+1)'(PRESCALE_16)) ||
                       (prescale == (EDGE_W+1)'(PRESCALE_32));
    assign fbits_ok  = (fbits_ext >= MIN_FRAME_BITS) && (fbits_ext <= MAX_FRAME_BITS);

    assign running   = (state_q == RUN);
    assign last_edge = EDGE_W'(presc_q - 1'b1);
    assign mid_lo    = EDGE_W'((presc_q >> 1) - 1'b1);
    assign win_off   = edge_cnt_q - mid_lo;
    assign final_bit = (bit_cnt_q == BIT_W'(fbits_q - 1'b1));

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        fbits_d      = fbits_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        cfg_err_d    = cfg_err_q;
        frame_done_d = 1'b0;

        if (reset_bit_cnt) begin
            state_d    = IDLE;
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                    if (enable) begin
                        state_d    = RUN;
                        // The start cycle itself counts as oversample 0 of bit 0.
                        edge_cnt_d = EDGE_W'(1);
                        presc_d    = presc_ok ? prescale : (EDGE_W+1)'(DEFAULT_PRESCALE);
                        fbits_d    = fbits_ok ? frame_bits : BIT_W'(DEFAULT_FRAME_BITS);
                        cfg_err_d  = !(presc_ok && fbits_ok);
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_d    = IDLE;
                        edge_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end else if (edge_cnt_q == last_edge) begin
                        edge_cnt_d = '0;
                        if (final_bit) begin
                            state_d      = DONE;
                            bit_cnt_d    = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                    if (!enable) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            presc_q      <= (EDGE_W+1)'(DEFAULT_PRESCALE);
            fbits_q      <= BIT_W'(DEFAULT_FRAME_BITS);
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            fbits_q      <= fbits_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign edge_cnt   = edge_cnt_q;
    assign bit_cnt    = bit_cnt_q;
    assign frame_done = frame_done_q;
    assign cfg_err    = cfg_err_q;
    assign bit_end    = running && (edge_cnt_q == last_edge);
    assign sample_stb = running && (win_off <= EDGE_W'(2));
    assign sample_idx = sample_stb ? win_off[1:0] : 2'd0;

endmodule
